// File: rtl/ship_controller.sv
// Player ship controller: turns tilt samples into a once-per-frame clamped x position,
// and a debounced fire button into a cooldown-limited one-cycle fire strobe.
module ship_controller #(
  parameter int X_MIN           = 0,
  parameter int X_MAX           = 572,
  parameter int X_INIT          = 286,
  parameter int DEADZONE        = 16,
  parameter int TILT_SHIFT      = 4,
  parameter int MAX_SPEED       = 8,
  parameter int STALE_FRAMES    = 8,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int COOLDOWN_FRAMES = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame,
  input  logic        tilt_valid,
  input  logic [15:0] tilt_x,
  input  logic        fire_n,
  output logic [15:0] ship_x,
  output logic        fire,
  output logic        cooldown_active,
  output logic [1:0]  state_dbg
);

  localparam int SW   = $clog2(STALE_FRAMES + 1);
  localparam int CW   = $clog2(COOLDOWN_FRAMES + 1);
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [SW-1:0]     STALE_V = SW'(STALE_FRAMES);
  localparam logic [CW-1:0]     COOL_V  = CW'(COOLDOWN_FRAMES);
  localparam logic [DB_W-1:0]   DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [16:0]       DZ_V    = 17'(DEADZONE);
  localparam logic [16:0]       MS_V    = 17'(MAX_SPEED);
  localparam logic signed [17:0] XMIN_S = 18'(X_MIN);
  localparam logic signed [17:0] XMAX_S = 18'(X_MAX);

  // Handshake: tilt_valid and frame are single-cycle strobes with no back-pressure;
  // every strobe is consumed in the cycle it is high (frame is ignored outside IDLE).

  typedef enum logic [1:0] {IDLE, CALC, APPLY} state_t;

  state_t            state_q, state_d;
  logic [15:0]       tilt_q, tilt_d;
  logic [SW-1:0]     stale_q, stale_d;
  logic [17:0]       vel_q, vel_d;
  logic [15:0]       ship_x_q, ship_x_d;
  logic              sync1_q, sync2_q;
  logic              btn_q, btn_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [CW-1:0]     cooldown_q, cooldown_d;
  logic              fire_q, fire_d;
  logic              cd_act_q, cd_act_d;

  logic [15:0]       tilt_eff;
  logic [SW-1:0]     stale_eff;
  logic [16:0]       ext, mag, above, shifted, sat;
  logic [17:0]       vel_calc;
  logic signed [17:0] sum_s;
  logic              press;

  // A sample arriving during CALC is bypassed straight into the velocity math.
  always_comb begin
    tilt_eff  = tilt_valid ? tilt_x : tilt_q;
    stale_eff = tilt_valid ? '0 : stale_q;
    ext       = {tilt_eff[15], tilt_eff};
    mag       = tilt_eff[15] ? (~ext + 17'd1) : ext;
    above     = mag - DZ_V;
    shifted   = above >> TILT_SHIFT;
    sat       = (shifted > MS_V) ? MS_V : shifted;
    if (mag <= DZ_V || stale_eff == STALE_V) begin
      vel_calc = '0;
    end else begin
      vel_calc = tilt_eff[15] ? (~{1'b0, sat} + 18'd1) : {1'b0, sat};
    end
    sum_s = $signed({2'b00, ship_x_q}) + $signed(vel_q);
  end

  always_comb begin
    tilt_d  = tilt_q;
    stale_d = stale_q;
    if (tilt_valid) begin
      tilt_d  = tilt_x;
      stale_d = '0;
    end else if (frame && stale_q != STALE_V) begin
      stale_d = stale_q + 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    vel_d    = vel_q;
    ship_x_d = ship_x_q;
    case (state_q)
      IDLE: if (frame) state_d = CALC;
      CALC: begin
        vel_d   = vel_calc;
        state_d = APPLY;
      end
      APPLY: begin
        if (sum_s < XMIN_S)      ship_x_d = XMIN_S[15:0];
        else if (sum_s > XMAX_S) ship_x_d = XMAX_S[15:0];
        else                     ship_x_d = sum_s[15:0];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Debounce counts only while the synced level disagrees with the accepted one.
  always_comb begin
    btn_d    = btn_q;
    db_cnt_d = db_cnt_q;
    press    = 1'b0;
    if (sync2_q == btn_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      btn_d    = sync2_q;
      db_cnt_d = '0;
      press    = ~sync2_q;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
    fire_d     = press && (cooldown_q == '0);
    cooldown_d = cooldown_q;
    if (fire_d)                          cooldown_d = COOL_V;
    else if (frame && cooldown_q != '0)  cooldown_d = cooldown_q - 1'b1;
    cd_act_d = (cooldown_q != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tilt_q     <= '0;
      stale_q    <= STALE_V;
      vel_q      <= '0;
      ship_x_q   <= 16'(X_INIT);
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      btn_q      <= 1'b1;
      db_cnt_q   <= '0;
      cooldown_q <= '0;
      fire_q     <= 1'b0;
      cd_act_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      tilt_q     <= tilt_d;
      stale_q    <= stale_d;
      vel_q      <= vel_d;
      ship_x_q   <= ship_x_d;
      sync1_q    <= fire_n;
      sync2_q    <= sync1_q;
      btn_q      <= btn_d;
      db_cnt_q   <= db_cnt_d;
      cooldown_q <= cooldown_d;
      fire_q     <= fire_d;
      cd_act_q   <= cd_act_d;
    end
  end

  assign ship_x          = ship_x_q;
  assign fire            = fire_q;
  assign cooldown_active = cd_act_q;
  assign state_dbg       = state_q;

endmodule
